// File: rtl/apb_slave_regs.sv
// APB register bank: ID, WAIT, SCRATCH, COUNT and general-purpose words.
// A programmable number of wait states is inserted before pready.
//
// Handshake: a transfer starts with one setup cycle (psel & ~penable).
// It completes on the edge where psel, penable and pready are all high.
// Dropping psel before that edge aborts it with no side effects.
module apb_slave_regs #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [3:0]            WAIT_RST   = 4'd2,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA9B0_0001
) (
    input  logic                    pclk_i,
    input  logic                    prst_i,
    input  logic [ADDR_WIDTH-1:0]   paddr_i,
    input  logic [2:0]              pprot_i,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
    input  logic [DATA_WIDTH-1:0]   pwdata_i,
    input  logic [DATA_WIDTH/8-1:0] pstrb_i,
    output logic                    pready_o,
    output logic [DATA_WIDTH-1:0]   prdata_o,
    output logic                    pslverr_o
);

    localparam int unsigned           IDX_W  = $clog2(NUM_REGS);
    localparam int unsigned           STRB_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] SPAN   = ADDR_WIDTH'(4 * NUM_REGS);

    localparam logic [IDX_W-1:0] IDX_ID    = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_WAIT  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_COUNT = IDX_W'(3);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t                              state_q, state_d;
    logic [3:0]                          cnt_q, cnt_d;
    logic                                err_q, err_d;
    logic                                wr_q, wr_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic [DATA_WIDTH-1:0]               prdata_q, prdata_d;
    logic [3:0]                          wait_q, wait_d;
    logic [DATA_WIDTH-1:0]               count_q, count_d;
    // Slots 2 and 4..NUM_REGS-1 hold data. Slots 0, 1 and 3 are never written
    // because those registers live in ID_VALUE, wait_q and count_q instead.
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;

    logic [ADDR_WIDTH-1:0] addr_off;
    logic [IDX_W-1:0]      addr_idx;
    logic                  in_range;
    logic                  setup_err;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  ready;
    logic                  unused_prot;

    // Only the privilege bit of pprot matters to this bank.
    assign unused_prot = ^pprot_i[2:1];

    // pready depends only on state and cnt, never on the APB inputs.
    assign ready     = (state_q == S_ACCESS) && (cnt_q == 4'd0);
    assign pready_o  = ready;
    assign pslverr_o = err_q & ready;
    assign prdata_o  = prdata_q;

    // Byte-wise merge: byte k takes new data only when its strobe is set.
    function automatic logic [DATA_WIDTH-1:0] byte_merge(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_v;
        for (int k = 0; k < STRB_W; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = wdata[8*k +: 8];
            end
        end
        return res;
    endfunction

    // Decode the current address: range check, access error and read value.
    always_comb begin
        addr_off  = paddr_i - BASE_ADDR;
        addr_idx  = addr_off[IDX_W+1:2];
        in_range  = (addr_off < SPAN);
        setup_err = !in_range ||
                    (pwrite_i && ((addr_idx == IDX_ID) || (addr_idx == IDX_COUNT) ||
                                  ((addr_idx == IDX_WAIT) && !pprot_i[0])));
        rd_val = '0;
        case (addr_idx)
            IDX_ID:    rd_val = ID_VALUE;
            IDX_WAIT:  rd_val = DATA_WIDTH'(wait_q);
            IDX_COUNT: rd_val = count_q;
            default:   rd_val = regs_q[addr_idx];
        endcase
    end

    // FSM next state: latch the transfer at setup, count wait states,
    // then commit on completion or drop everything on abort.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        wr_d     = wr_q;
        idx_d    = idx_q;
        prdata_d = prdata_q;
        wait_d   = wait_q;
        count_d  = count_q;
        regs_d   = regs_q;
        case (state_q)
            S_IDLE: begin
                if (psel_i && !penable_i) begin
                    state_d  = S_ACCESS;
                    cnt_d    = wait_q;
                    err_d    = setup_err;
                    wr_d     = pwrite_i;
                    idx_d    = addr_idx;
                    prdata_d = setup_err ? '0 : rd_val;
                end
            end
            S_ACCESS: begin
                if (!psel_i) begin
                    state_d = S_IDLE;
                end else if (penable_i) begin
                    if (ready) begin
                        state_d = S_IDLE;
                        count_d = count_q + DATA_WIDTH'(1);
                        if (wr_q && !err_q) begin
                            if (idx_q == IDX_WAIT) begin
                                if (pstrb_i[0]) begin
                                    wait_d = pwdata_i[3:0];
                                end
                            end else begin
                                regs_d[idx_q] = byte_merge(regs_q[idx_q], pwdata_i, pstrb_i);
                            end
                        end
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and register file; reset wins over any transfer in flight.
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            err_q    <= 1'b0;
            wr_q     <= 1'b0;
            idx_q    <= '0;
            prdata_q <= '0;
            wait_q   <= WAIT_RST;
            count_q  <= '0;
            regs_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            wr_q     <= wr_d;
            idx_q    <= idx_d;
            prdata_q <= prdata_d;
            wait_q   <= wait_d;
            count_q  <= count_d;
            regs_q   <= regs_d;
        end
    end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Testbench for apb_slave_regs: directed APB transfers against a register-level model.
module tb_apb_slave_regs;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          NREG = 8;
    localparam logic [31:0] ID   = 32'hA9B0_0001;

    // ---------------- clock / reset ----------------
    logic        pclk_i = 1'b0;
    logic        prst_i;
    logic [31:0] paddr_i;
    logic [2:0]  pprot_i;
    logic        psel_i;
    logic        penable_i;
    logic        pwrite_i;
    logic [31:0] pwdata_i;
    logic [3:0]  pstrb_i;
    logic        pready_o;
    logic [31:0] prdata_o;
    logic        pslverr_o;

    always #5 pclk_i = ~pclk_i;

    apb_slave_regs #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .NUM_REGS  (NREG),
        .BASE_ADDR (BASE),
        .WAIT_RST  (4'd2),
        .ID_VALUE  (ID)
    ) dut (
        .pclk_i   (pclk_i),
        .prst_i   (prst_i),
        .paddr_i  (paddr_i),
        .pprot_i  (pprot_i),
        .psel_i   (psel_i),
        .penable_i(penable_i),
        .pwrite_i (pwrite_i),
        .pwdata_i (pwdata_i),
        .pstrb_i  (pstrb_i),
        .pready_o (pready_o),
        .prdata_o (prdata_o),
        .pslverr_o(pslverr_o)
    );

    // ---------------- scoreboard state ----------------
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];
    logic        chk_on;
    logic        exp_rdy;
    logic        exp_err;
    logic        rd_chk;
    logic [31:0] exp_rd;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h, expected %h", name, $time, got, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs[NREG];
    logic [3:0]  m_wait;
    logic [31:0] m_count;

    task automatic m_reset();
        m_wait  = 4'd2;
        m_count = 32'd0;
        for (int i = 0; i < NREG; i++) m_regs[i] = 32'd0;
    endtask

    function automatic bit m_err(input bit wr, input logic [31:0] addr, input logic [2:0] prot);
        int unsigned i;
        if (addr < BASE || addr >= BASE + 4 * NREG) return 1'b1;
        i = (addr - BASE) >> 2;
        if (wr && (i == 0 || i == 3)) return 1'b1;
        if (wr && i == 1 && !prot[0]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input int i);
        case (i)
            0:       return ID;
            1:       return {28'd0, m_wait};
            3:       return m_count;
            default: return m_regs[i];
        endcase
    endfunction

    task automatic m_write(input int i, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] cur;
        cur = m_read(i);
        for (int k = 0; k < 4; k++) if (strb[k]) cur[8*k +: 8] = data[8*k +: 8];
        if (i == 1) m_wait = cur[3:0];
        else m_regs[i] = cur;
    endtask

    // ---------------- compare process ----------------
    always @(negedge pclk_i) begin
        if (chk_on) begin
            chk("pready", {31'd0, pready_o}, {31'd0, exp_rdy});
            chk("pslverr", {31'd0, pslverr_o}, {31'd0, exp_rdy & exp_err});
            if (rd_chk) chk("prdata_hold", prdata_o, exp_rd);
            if (pready_o && psel_i && penable_i && !pwrite_i) begin
                if (exp_q.size() == 0) chk("rd_queue_underflow", exp_q.size(), 1);
                else chk("rd_data", prdata_o, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after the edge that ends
    // the transfer. mode 0: normal, 1: drop psel after access cycle 'at',
    // 2: assert reset after access cycle 'at'.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [2:0] prot,
                        input int mode, input int at,
                        output logic [31:0] rd, output logic er, output int len);
        bit          e;
        logic [31:0] r;
        int          n;
        int          acc;
        logic        got_rdy;
        e = m_err(wr, addr, prot);
        r = e ? 32'd0 : m_read(int'((addr - BASE) >> 2));
        n = m_wait;
        if (!wr && mode == 0) exp_q.push_back(r);
        paddr_i   = addr;
        pprot_i   = prot;
        pwrite_i  = wr;
        pwdata_i  = data;
        pstrb_i   = strb;
        psel_i    = 1'b1;
        penable_i = 1'b0;
        exp_rdy   = 1'b0;
        exp_err   = e;
        @(posedge pclk_i); #1;
        penable_i = 1'b1;
        exp_rd    = r;
        rd_chk    = !wr;
        acc = 0;
        len = 1;
        got_rdy = 1'b0;
        forever begin
            acc++;
            len++;
            exp_rdy = (acc == n + 1);
            @(negedge pclk_i);
            got_rdy = pready_o;
            rd      = prdata_o;
            er      = pslverr_o;
            @(posedge pclk_i); #1;
            if (mode == 0 && got_rdy) break;
            if (mode != 0 && acc == at + 1) break;
            if (acc >= 20) begin
                chk("xfer_timeout", {31'd0, got_rdy}, 32'd1);
                break;
            end
            if (mode == 1 && acc == at) begin
                psel_i    = 1'b0;
                penable_i = 1'b0;
            end
            if (mode == 2 && acc == at) prst_i = 1'b1;
        end
        psel_i    = 1'b0;
        penable_i = 1'b0;
        prst_i    = 1'b0;
        exp_rdy   = 1'b0;
        if (mode == 0 && got_rdy) begin
            if (wr && !e) m_write(int'((addr - BASE) >> 2), data, strb);
            m_count++;
        end else if (mode == 2) begin
            m_reset();
            exp_rd = 32'd0;
            rd_chk = 1'b1;
        end
    endtask

    task automatic rd_lit(input string name, input logic [31:0] addr,
                          input logic [31:0] exp_data, input int exp_len);
        logic [31:0] rd;
        logic        er;
        int          ln;
        xfer(1'b0, addr, 32'd0, 4'd0, 3'd0, 0, 0, rd, er, ln);
        chk({name, "_rdata"}, rd, exp_data);
        chk({name, "_len"}, ln, exp_len);
    endtask

    task automatic wr_lit(input string name, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [2:0] prot,
                          input logic exp_er, input int exp_len);
        logic [31:0] rd;
        logic        er;
        int          ln;
        xfer(1'b1, addr, data, strb, prot, 0, 0, rd, er, ln);
        chk({name, "_err"}, {31'd0, er}, {31'd0, exp_er});
        chk({name, "_len"}, ln, exp_len);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] rd;
        logic        er;
        int          ln;
        prst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
        paddr_i = '0; pprot_i = '0; pwdata_i = '0; pstrb_i = '0;
        chk_on = 1'b0; exp_rdy = 1'b0; exp_err = 1'b0; rd_chk = 1'b0; exp_rd = '0;
        m_reset();
        repeat (3) @(posedge pclk_i);
        #1;
        prst_i = 1'b0;
        chk_on = 1'b1;
        rd_chk = 1'b1;

        // Reset defaults (COUNT first so it still reads 0).
        rd_lit("rst_count", BASE + 12, 32'd0, 4);
        rd_lit("rst_id", BASE + 0, 32'hA9B0_0001, 4);
        rd_lit("rst_wait", BASE + 4, 32'd2, 4);
        rd_lit("rst_scratch", BASE + 8, 32'd0, 4);

        // Strobed writes to SCRATCH and a GP register.
        wr_lit("scr_w1", BASE + 8, 32'h1122_3344, 4'hF, 3'd0, 1'b0, 4);
        wr_lit("scr_w2", BASE + 8, 32'hAABB_CCDD, 4'b0101, 3'd0, 1'b0, 4);
        rd_lit("scr_merge", BASE + 8, 32'h11BB_33DD, 4);
        rd_lit("count_7", BASE + 12, 32'd7, 4);
        wr_lit("gp5_w", BASE + 20, 32'hDEAD_BEEF, 4'b1010, 3'd0, 1'b0, 4);
        rd_lit("gp5_r", BASE + 20, 32'hDE00_BE00, 4);

        // Wait-state programming.
        wr_lit("wait0_w", BASE + 4, 32'd0, 4'hF, 3'b001, 1'b0, 4);
        rd_lit("wait0_xfer", BASE + 8, 32'h11BB_33DD, 2);
        wr_lit("wait15_w", BASE + 4, 32'hFFFF_FFFF, 4'hF, 3'b001, 1'b0, 2);
        rd_lit("wait15_xfer", BASE + 8, 32'h11BB_33DD, 17);
        wr_lit("wait_unpriv", BASE + 4, 32'd3, 4'hF, 3'b000, 1'b1, 17);
        rd_lit("wait_kept", BASE + 4, 32'd15, 17);
        wr_lit("wait3_w", BASE + 4, 32'd3, 4'hF, 3'b001, 1'b0, 17);

        // Error decode: COUNT moves by one per completed transfer, errors included.
        xfer(1'b0, BASE + 12, 32'd0, 4'd0, 3'd0, 0, 0, rd, er, ln);
        wr_lit("err_wr_id", BASE + 0, 32'h1234_5678, 4'hF, 3'b001, 1'b1, 5);
        wr_lit("err_wr_count", BASE + 12, 32'h1234_5678, 4'hF, 3'b001, 1'b1, 5);
        rd_lit("err_rd_hi", BASE + 4 * NREG, 32'd0, 5);
        rd_lit("err_rd_lo", BASE - 4, 32'd0, 5);
        rd_lit("err_count", BASE + 12, rd + 32'd5, 5);
        rd_lit("err_id_kept", BASE + 0, 32'hA9B0_0001, 5);

        // Ignored low address bits and an all-zero strobe.
        wr_lit("lowbits_w", BASE + 8 + 3, 32'h1234_5678, 4'hF, 3'd0, 1'b0, 5);
        wr_lit("strb0_w", BASE + 8, 32'hFFFF_FFFF, 4'h0, 3'd0, 1'b0, 5);
        rd_lit("lowbits_r", BASE + 8, 32'h1234_5678, 5);

        // Abort during wait states: no write, no COUNT increment.
        xfer(1'b0, BASE + 12, 32'd0, 4'd0, 3'd0, 0, 0, rd, er, ln);
        xfer(1'b1, BASE + 8, 32'h5555_5555, 4'hF, 3'd0, 1, 1, exp_rd, er, ln);
        rd_chk = 1'b0;
        rd_lit("abort_count", BASE + 12, rd + 32'd1, 5);
        rd_lit("abort_scratch", BASE + 8, 32'h1234_5678, 5);

        // Reset in the middle of a write.
        xfer(1'b1, BASE + 8, 32'hCAFE_F00D, 4'hF, 3'd0, 2, 1, rd, er, ln);
        rd_lit("rrst_count", BASE + 12, 32'd0, 4);
        rd_lit("rrst_wait", BASE + 4, 32'd2, 4);
        rd_lit("rrst_scratch", BASE + 8, 32'd0, 4);
        rd_lit("rrst_gp5", BASE + 20, 32'd0, 4);

        repeat (2) @(posedge pclk_i);
        chk("rd_queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
